// File: rtl/asteroids_pkg.sv
// Shared definitions for the asteroids game datapath.
// Holds the visible screen size, the 3-bit heading encoding and a helper that
// turns a heading plus a speed into a signed per-frame displacement.
package asteroids_pkg;

  localparam int unsigned XMAX = 640;
  localparam int unsigned YMAX = 480;

  typedef enum logic [2:0] {
    DirN  = 3'd0,
    DirNe = 3'd1,
    DirE  = 3'd2,
    DirSe = 3'd3,
    DirS  = 3'd4,
    DirSw = 3'd5,
    DirW  = 3'd6,
    DirNw = 3'd7
  } dir_e;

  // 10-bit two's complement is enough: positions wrap modulo 1024 anyway.
  typedef struct packed {
    logic signed [9:0] dx;
    logic signed [9:0] dy;
  } vel_t;

  // Screen Y grows downwards, so north is negative dy.
  function automatic vel_t dir_vel(input dir_e dir, input int unsigned speed);
    vel_t              v;
    logic signed [9:0] s;
    s = 10'(speed);
    v = '0;
    case (dir)
      DirN:    v.dy = -s;
      DirNe:   begin v.dx = s;  v.dy = -s; end
      DirE:    v.dx = s;
      DirSe:   begin v.dx = s;  v.dy = s;  end
      DirS:    v.dy = s;
      DirSw:   begin v.dx = -s; v.dy = s;  end
      DirW:    v.dx = -s;
      DirNw:   begin v.dx = -s; v.dy = -s; end
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/bullet_pool_if.sv
// Bus between the game logic and the bullet pool.
//   frame_tick, fire, ship_x/y/dir : launch control from the game
//   kill                           : per-slot retire from the collision detector
//   px, py                         : current scan position
//   pixels, active, shots_fired    : pool outputs
// master = game side driving the pool, slave = the pool itself.
interface bullet_pool_if #(
  parameter int unsigned NUM_BULLETS = 4
);
  logic                   frame_tick;
  logic                   fire;
  logic [9:0]             ship_x;
  logic [9:0]             ship_y;
  logic [2:0]             ship_dir;
  logic [NUM_BULLETS-1:0] kill;
  logic [9:0]             px;
  logic [9:0]             py;
  logic [NUM_BULLETS-1:0] pixels;
  logic [NUM_BULLETS-1:0] active;
  logic [7:0]             shots_fired;

  modport master (
    output frame_tick, fire, ship_x, ship_y, ship_dir, kill, px, py,
    input  pixels, active, shots_fired
  );

  modport slave (
    input  frame_tick, fire, ship_x, ship_y, ship_dir, kill, px, py,
    output pixels, active, shots_fired
  );
endinterface

// File: rtl/bullet_slot.sv
// One bullet slot: idle/flying flag, position, heading, life counter, the
// per-frame move with off-screen/lifetime retirement, and the registered
// pixel-coverage compare.
//   clk, reset_game_n : clock, synchronous active-low reset
//   frame_tick_i      : move strobe
//   launch_i          : load ship state into this slot (slot must be idle)
//   kill_i            : retire now; beats launch and move
//   ship_*_i          : spawn state sampled on launch
//   px_i, py_i        : scan position
//   active_o, pixel_o : slot flying / slot covers the previous scan position
module bullet_slot
  import asteroids_pkg::*;
#(
  parameter int unsigned SPEED    = 4,
  parameter int unsigned LIFETIME = 60,
  parameter int unsigned SIZE     = 2,
  parameter int unsigned XMAX     = asteroids_pkg::XMAX,
  parameter int unsigned YMAX     = asteroids_pkg::YMAX
) (
  input  logic       clk,
  input  logic       reset_game_n,
  input  logic       frame_tick_i,
  input  logic       launch_i,
  input  logic       kill_i,
  input  logic [9:0] ship_x_i,
  input  logic [9:0] ship_y_i,
  input  dir_e       ship_dir_i,
  input  logic [9:0] px_i,
  input  logic [9:0] py_i,
  output logic       active_o,
  output logic       pixel_o
);

  localparam int unsigned LifeW  = $clog2(LIFETIME + 1);
  localparam logic [9:0]  XLim   = 10'(XMAX);
  localparam logic [9:0]  YLim   = 10'(YMAX);
  localparam logic [10:0] Size11 = 11'(SIZE);

  logic             active_q;
  logic             pixel_q;
  logic [9:0]       x_q, y_q;
  dir_e             dir_q;
  logic [LifeW-1:0] life_q;

  vel_t       vel;
  logic [9:0] x_nxt, y_nxt;
  logic       retire;
  logic       hit;

  always_comb begin
    vel   = dir_vel(dir_q, SPEED);
    // Modulo-1024 add: leaving left/top wraps to >= 1000 and fails the bound check.
    x_nxt = x_q + vel.dx;
    y_nxt = y_q + vel.dy;
    retire = (x_nxt >= XLim) || (y_nxt >= YLim) || (life_q == LifeW'(1));
    // 11-bit compare so x+SIZE near 1023 does not wrap.
    hit = ({1'b0, px_i} >= {1'b0, x_q}) && ({1'b0, px_i} < ({1'b0, x_q} + Size11)) &&
          ({1'b0, py_i} >= {1'b0, y_q}) && ({1'b0, py_i} < ({1'b0, y_q} + Size11));
  end

  always_ff @(posedge clk) begin
    if (!reset_game_n) begin
      active_q <= 1'b0;
      pixel_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      dir_q    <= DirN;
      life_q   <= '0;
    end else begin
      pixel_q <= active_q & hit;
      if (kill_i) begin
        active_q <= 1'b0;
      end else if (launch_i) begin
        active_q <= 1'b1;
        x_q      <= ship_x_i;
        y_q      <= ship_y_i;
        dir_q    <= ship_dir_i;
        life_q   <= LifeW'(LIFETIME);
      end else if (frame_tick_i && active_q) begin
        x_q    <= x_nxt;
        y_q    <= y_nxt;
        life_q <= life_q - LifeW'(1);
        if (retire) active_q <= 1'b0;
      end
    end
  end

  assign active_o = active_q;
  assign pixel_o  = pixel_q;

endmodule

// File: rtl/bullet_pool.sv
// Pool of player bullets. Captures fire presses, launches into the lowest free
// slot on a frame tick subject to a cooldown, and counts launches.
//   clk          : pixel clock
//   reset_game_n : synchronous active-low game reset
//   bus          : bullet_pool_if slave (control in, pixels/active/shots_fired out)
module bullet_pool
  import asteroids_pkg::*;
#(
  parameter int unsigned NUM_BULLETS = 4,
  parameter int unsigned SPEED       = 4,
  parameter int unsigned LIFETIME    = 60,
  parameter int unsigned COOLDOWN    = 8,
  parameter int unsigned SIZE        = 2,
  parameter int unsigned XMAX        = asteroids_pkg::XMAX,
  parameter int unsigned YMAX        = asteroids_pkg::YMAX
) (
  input logic          clk,
  input logic          reset_game_n,
  bullet_pool_if.slave bus
);

  localparam int unsigned CdW = $clog2(COOLDOWN + 2);

  logic                   fire_q;
  logic                   fire_pending_q, fire_pending_d;
  logic [CdW-1:0]         cooldown_q, cooldown_d;
  logic [7:0]             shots_q, shots_d;
  logic [NUM_BULLETS-1:0] active, pixels, free, sel, launch;
  logic                   found, launch_en;

  // A slot being killed this cycle is not offered for launch.
  assign free = ~active & ~bus.kill;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (free[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  // The counter includes the current tick, so a value of 1 is already clear.
  assign launch_en = bus.frame_tick && fire_pending_q && (cooldown_q <= CdW'(1)) && found;
  assign launch    = sel & {NUM_BULLETS{launch_en}};

  always_comb begin
    fire_pending_d = fire_pending_q;
    if (bus.fire && !fire_q)  fire_pending_d = 1'b1;
    else if (bus.frame_tick)  fire_pending_d = 1'b0;

    cooldown_d = cooldown_q;
    if (bus.frame_tick) begin
      if (launch_en)                cooldown_d = CdW'(COOLDOWN);
      else if (cooldown_q != '0)    cooldown_d = cooldown_q - CdW'(1);
    end

    shots_d = launch_en ? shots_q + 8'd1 : shots_q;
  end

  // Tracks fire even in reset so a press held across reset is not a new edge.
  always_ff @(posedge clk) begin
    fire_q <= bus.fire;
  end

  always_ff @(posedge clk) begin
    if (!reset_game_n) begin
      fire_pending_q <= 1'b0;
      cooldown_q     <= '0;
      shots_q        <= '0;
    end else begin
      fire_pending_q <= fire_pending_d;
      cooldown_q     <= cooldown_d;
      shots_q        <= shots_d;
    end
  end

  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
    bullet_slot #(
      .SPEED    (SPEED),
      .LIFETIME (LIFETIME),
      .SIZE     (SIZE),
      .XMAX     (XMAX),
      .YMAX     (YMAX)
    ) u_slot (
      .clk          (clk),
      .reset_game_n (reset_game_n),
      .frame_tick_i (bus.frame_tick),
      .launch_i     (launch[i]),
      .kill_i       (bus.kill[i]),
      .ship_x_i     (bus.ship_x),
      .ship_y_i     (bus.ship_y),
      .ship_dir_i   (dir_e'(bus.ship_dir)),
      .px_i         (bus.px),
      .py_i         (bus.py),
      .active_o     (active[i]),
      .pixel_o      (pixels[i])
    );
  end

  assign bus.active      = active;
  assign bus.pixels      = pixels;
  assign bus.shots_fired = shots_q;

endmodule

// File: tb/tb_bullet_pool.sv
// Self-checking bench for bullet_pool: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// frame-level behavioural model.
module tb_bullet_pool;
  localparam int NB       = 4;
  localparam int SPEED    = 4;
  localparam int LIFETIME = 60;
  localparam int COOLDOWN = 8;
  localparam int SIZE     = 2;
  localparam int XMAX     = 640;
  localparam int YMAX     = 480;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bullet_pool_if #(.NUM_BULLETS(NB)) bus();

  bullet_pool #(
    .NUM_BULLETS (NB),
    .SPEED       (SPEED),
    .LIFETIME    (LIFETIME),
    .COOLDOWN    (COOLDOWN),
    .SIZE        (SIZE),
    .XMAX        (XMAX),
    .YMAX        (YMAX)
  ) dut (
    .clk          (clk),
    .reset_game_n (rst_n),
    .bus          (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Behavioural model, stepped once per clock edge.
  bit             m_alive[NB];
  int             m_x[NB], m_y[NB], m_dir[NB], m_life[NB];
  bit             m_pend, m_fire_prev;
  int             m_frame, m_last, m_shots;
  logic [NB-1:0]  m_pix;
  int dx_unit[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int dy_unit[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

  function automatic logic [NB-1:0] m_active();
    logic [NB-1:0] v;
    for (int i = 0; i < NB; i++) v[i] = m_alive[i];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_step();
    bit rise;
    int ls, px, py, nx, ny;
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) m_alive[i] = 1'b0;
      m_pix       = '0;
      m_pend      = 1'b0;
      m_shots     = 0;
      m_frame     = 0;
      m_last      = -1000;
      m_fire_prev = bus.fire;
    end else begin
      px = int'(bus.px);
      py = int'(bus.py);
      for (int i = 0; i < NB; i++)
        m_pix[i] = m_alive[i] && px >= m_x[i] && px < m_x[i] + SIZE &&
                   py >= m_y[i] && py < m_y[i] + SIZE;
      rise        = bus.fire && !m_fire_prev;
      m_fire_prev = bus.fire;
      if (bus.frame_tick) begin
        m_frame++;
        ls = -1;
        if (m_pend && (m_frame - m_last >= COOLDOWN))
          for (int i = 0; i < NB; i++)
            if (ls < 0 && !m_alive[i] && !bus.kill[i]) ls = i;
        for (int i = 0; i < NB; i++) begin
          if (bus.kill[i]) m_alive[i] = 1'b0;
          else if (m_alive[i]) begin
            nx = (m_x[i] + SPEED * dx_unit[m_dir[i]] + 1024) % 1024;
            ny = (m_y[i] + SPEED * dy_unit[m_dir[i]] + 1024) % 1024;
            m_x[i] = nx;
            m_y[i] = ny;
            m_life[i]--;
            if (nx >= XMAX || ny >= YMAX || m_life[i] == 0) m_alive[i] = 1'b0;
          end
        end
        if (ls >= 0) begin
          m_alive[ls] = 1'b1;
          m_x[ls]     = int'(bus.ship_x);
          m_y[ls]     = int'(bus.ship_y);
          m_dir[ls]   = int'(bus.ship_dir);
          m_life[ls]  = LIFETIME;
          m_last      = m_frame;
          m_shots     = (m_shots + 1) % 256;
        end
      end else begin
        for (int i = 0; i < NB; i++) if (bus.kill[i]) m_alive[i] = 1'b0;
      end
      if (rise) m_pend = 1'b1;
      else if (bus.frame_tick) m_pend = 1'b0;
    end
  endtask

  // Single compare process against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("active", 32'(bus.active), 32'(m_active()));
      check("pixels", 32'(bus.pixels), 32'(m_pix));
      check("shots_fired", 32'(bus.shots_fired), 32'(m_shots));
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    cycle();
    bus.frame_tick = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic pulse_fire();
    bus.fire = 1'b1;
    cycle();
    bus.fire = 1'b0;
    cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic set_ship(input int x, input int y, input int d);
    bus.ship_x   = 10'(x);
    bus.ship_y   = 10'(y);
    bus.ship_dir = 3'(d);
  endtask

  // Wait out the cooldown from a launch on the previous tick, then launch.
  task automatic launch_after_cooldown();
    repeat (7) tick();
    pulse_fire();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  int shots_log[21];
  int since_tick;

  initial begin
    bus.frame_tick = 1'b0;
    bus.fire       = 1'b0;
    bus.kill       = '0;
    bus.px         = '0;
    bus.py         = '0;
    set_ship(0, 0, 0);
    cycle();
    chk_en = 1'b1;
    cycle();
    rst_n = 1'b1;
    cycle();
    check("reset_active", 32'(bus.active), 32'h0);
    check("reset_pixels", 32'(bus.pixels), 32'h0);
    check("reset_shots", 32'(bus.shots_fired), 32'h0);

    // Launch east from (100,200) and move once.
    set_ship(100, 200, 2);
    pulse_fire();
    tick();
    check("launch_active", 32'(bus.active), 32'h1);
    bus.px = 10'd100; bus.py = 10'd200;
    cycle();
    check("pix_spawn", 32'(bus.pixels), 32'h1);
    bus.px = 10'd0;
    tick();
    bus.px = 10'd104; bus.py = 10'd200;
    cycle();
    check("pix_moved", 32'(bus.pixels), 32'h1);
    bus.px = 10'd106;
    cycle();
    check("pix_right_edge", 32'(bus.pixels), 32'h0);
    bus.px = 10'd105; bus.py = 10'd201;
    cycle();
    check("pix_inner_corner", 32'(bus.pixels), 32'h1);
    bus.py = 10'd202;
    cycle();
    check("pix_bottom_edge", 32'(bus.pixels), 32'h0);
    bus.kill = 4'b0001;
    cycle();
    bus.kill = '0;
    check("kill_slot0", 32'(bus.active), 32'h0);

    // Cooldown: re-press every frame for 20 frames.
    do_reset();
    set_ship(300, 200, 0);
    for (int t = 1; t <= 20; t++) begin
      bus.fire = 1'b0;
      cycle();
      bus.fire = 1'b1;
      cycle();
      tick();
      shots_log[t] = int'(bus.shots_fired);
    end
    bus.fire = 1'b0;
    check("cd_tick1", 32'(shots_log[1]), 32'd1);
    check("cd_tick8", 32'(shots_log[8]), 32'd1);
    check("cd_tick9", 32'(shots_log[9]), 32'd2);
    check("cd_tick16", 32'(shots_log[16]), 32'd2);
    check("cd_tick17", 32'(shots_log[17]), 32'd3);
    check("cd_tick20", 32'(shots_log[20]), 32'd3);
    check("cd_active", 32'(bus.active), 32'h7);

    // Pool full.
    repeat (5) tick();
    pulse_fire();
    tick();
    check("fill_active", 32'(bus.active), 32'hF);
    check("fill_shots", 32'(bus.shots_fired), 32'd4);
    repeat (8) tick();
    pulse_fire();
    tick();
    check("full_no_launch", 32'(bus.shots_fired), 32'd4);
    bus.kill = 4'b0001;
    cycle();
    bus.kill = '0;
    tick();
    check("full_pending_dropped", 32'(bus.shots_fired), 32'd4);
    check("full_after_kill", 32'(bus.active), 32'hE);
    bus.kill = 4'b0100;
    cycle();
    bus.kill = '0;
    check("kill_slot2", 32'(bus.active), 32'hA);

    // Refill, then kill slot 1 on the launch tick.
    pulse_fire();
    tick();
    repeat (7) tick();
    pulse_fire();
    tick();
    check("refill_active", 32'(bus.active), 32'hF);
    repeat (7) tick();
    pulse_fire();
    bus.frame_tick = 1'b1;
    bus.kill       = 4'b0010;
    cycle();
    bus.frame_tick = 1'b0;
    bus.kill       = '0;
    cycle();
    check("kill_tick_no_launch", 32'(bus.shots_fired), 32'd6);
    check("kill_tick_active", 32'(bus.active), 32'hD);
    pulse_fire();
    tick();
    check("reuse_slot1", 32'(bus.active), 32'hF);

    // Boundaries and lifetime.
    do_reset();
    set_ship(2, 100, 6);
    pulse_fire();
    tick();
    check("west_launch", 32'(bus.active), 32'h1);
    tick();
    check("west_exit", 32'(bus.active), 32'h0);
    do_reset();
    set_ship(50, 478, 4);
    pulse_fire();
    tick();
    tick();
    check("south_exit", 32'(bus.active), 32'h0);
    do_reset();
    set_ship(0, 0, 2);
    pulse_fire();
    tick();
    repeat (LIFETIME - 1) tick();
    check("life_59", 32'(bus.active), 32'h1);
    tick();
    check("life_60", 32'(bus.active), 32'h0);

    // Reset mid-flight with 3 flying and 5 shots.
    do_reset();
    set_ship(320, 240, 0);
    pulse_fire();
    tick();
    launch_after_cooldown();
    launch_after_cooldown();
    bus.kill = 4'b0011;
    cycle();
    bus.kill = '0;
    launch_after_cooldown();
    launch_after_cooldown();
    check("pre_reset_shots", 32'(bus.shots_fired), 32'd5);
    check("pre_reset_active", 32'(bus.active), 32'h7);
    bus.px = 10'd320; bus.py = 10'd240;
    cycle();
    check("pre_reset_pix", 32'(bus.pixels), 32'h2);
    rst_n    = 1'b0;
    bus.fire = 1'b1;
    cycle();
    check("rst_active", 32'(bus.active), 32'h0);
    check("rst_pixels", 32'(bus.pixels), 32'h0);
    check("rst_shots", 32'(bus.shots_fired), 32'h0);
    rst_n = 1'b1;
    cycle();
    tick();
    check("rst_fire_ignored", 32'(bus.shots_fired), 32'h0);
    bus.fire = 1'b0;

    // Randomized traffic.
    do_reset();
    since_tick = 0;
    for (int c = 0; c < 4000; c++) begin
      int j;
      since_tick++;
      bus.frame_tick = (since_tick >= 3) && ($urandom_range(0, 15) == 0);
      if (bus.frame_tick) since_tick = 0;
      if ($urandom_range(0, 2) == 0) bus.fire = ~bus.fire;
      for (int k = 0; k < NB; k++) bus.kill[k] = ($urandom_range(0, 63) == 0);
      set_ship($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 7));
      j = $urandom_range(0, NB - 1);
      if (m_alive[j] && $urandom_range(0, 1) == 1) begin
        bus.px = 10'(m_x[j] + $urandom_range(0, 2));
        bus.py = 10'(m_y[j] + $urandom_range(0, 2));
      end else begin
        bus.px = 10'($urandom_range(0, 1023));
        bus.py = 10'($urandom_range(0, 1023));
      end
      rst_n = ($urandom_range(0, 999) != 0);
      cycle();
    end
    rst_n          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.fire       = 1'b0;
    bus.kill       = '0;
    cycle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
